// File: rtl/mips_chk_pkg.sv
// Shared types and constants for the MIPS run monitor / result scoreboard.
package mips_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CAUSE_NOP = 0;
    localparam int CAUSE_CC  = 1;

    localparam int DEF_NOP_TIMEOUT = 20;
    localparam int DEF_CC_TIMEOUT  = 10000;

    // A single group still needs a one-bit index port.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mips_chk_timeout.sv
// RUN-phase cycle counter and NOP-streak counter; flags report whether the
// value being written this edge reaches a timeout.
module mips_chk_timeout
    import mips_chk_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int CC_WIDTH    = 16,
    parameter int NOP_TIMEOUT = DEF_NOP_TIMEOUT,
    parameter int CC_TIMEOUT  = DEF_CC_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_start,
    input  logic                  i_count,
    input  logic [WORD_WIDTH-1:0] i_inst,
    output logic [CC_WIDTH-1:0]   o_cycles,
    output logic                  o_nopHit,
    output logic                  o_ccHit
);

    localparam int NOP_W = (NOP_TIMEOUT > 0) ? $clog2(NOP_TIMEOUT + 1) : 1;

    logic [CC_WIDTH-1:0] r_cycles;
    logic [CC_WIDTH-1:0] w_cyclesNext;
    logic [NOP_W-1:0]    r_nopCnt;
    logic [NOP_W-1:0]    w_nopNext;
    logic                w_isNop;

    // The start edge is itself the first counted cycle.
    always_comb begin
        w_isNop = (i_inst == '0);
        if (i_start) begin
            w_cyclesNext = CC_WIDTH'(1);
            w_nopNext    = w_isNop ? NOP_W'(1) : '0;
        end else begin
            w_cyclesNext = (&r_cycles) ? r_cycles : r_cycles + CC_WIDTH'(1);
            if (!w_isNop) begin
                w_nopNext = '0;
            end else begin
                w_nopNext = (&r_nopCnt) ? r_nopCnt : r_nopCnt + NOP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cycles <= '0;
            r_nopCnt <= '0;
        end else if (i_start || i_count) begin
            r_cycles <= w_cyclesNext;
            r_nopCnt <= w_nopNext;
        end
    end

    assign o_cycles = r_cycles;
    assign o_nopHit = (w_nopNext == NOP_W'(NOP_TIMEOUT));
    assign o_ccHit  = (64'(w_cyclesNext) >= 64'(CC_TIMEOUT));

endmodule

// File: rtl/mips_result_checker.sv
// Run monitor and per-group result scoreboard for the pipelined MIPS harness.
// Define MISMATCH_LOG_EN to drive the mm_* mismatch report ports.
module mips_result_checker
    import mips_chk_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int GROUPS      = 13,
    parameter int CNT_WIDTH   = 8,
    parameter int CC_WIDTH    = 16,
    parameter int NOP_TIMEOUT = DEF_NOP_TIMEOUT,
    parameter int CC_TIMEOUT  = DEF_CC_TIMEOUT,
    localparam int IDX_W      = idxWidth(GROUPS)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  run,
    input  logic [WORD_WIDTH-1:0] inst,
    input  logic                  cfg_wr,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [CNT_WIDTH-1:0]  cfg_count,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [WORD_WIDTH-1:0] act_rdata,
    input  logic [WORD_WIDTH-1:0] exp_rdata,
    output logic [CNT_WIDTH-1:0]  score,
    output logic [CC_WIDTH-1:0]   cycles,
    output logic [1:0]            cause,
    output logic                  busy,
    output logic                  done,
    output logic                  mm_valid,
    output logic [ADDR_WIDTH-1:0] mm_addr,
    output logic [WORD_WIDTH-1:0] mm_act,
    output logic [WORD_WIDTH-1:0] mm_exp
);

    localparam int TOT_W = ADDR_WIDTH + 1;

    state_t               r_state;
    state_t               w_stateNext;
    logic [CNT_WIDTH-1:0] r_count [GROUPS];
    logic [CNT_WIDTH-1:0] r_score [GROUPS];
    logic [TOT_W-1:0]     w_cumEnd [GROUPS];
    logic [TOT_W-1:0]     w_total;
    logic [TOT_W-1:0]     r_issueAddr;
    logic [TOT_W-1:0]     r_cmpAddr;
    logic                 r_cmpValid;
    logic [IDX_W-1:0]     w_cmpGrp;
    logic [1:0]           r_cause;
    logic                 w_start;
    logic                 w_count;
    logic                 w_nopHit;
    logic                 w_ccHit;
    logic                 w_timeout;
    logic                 w_lastCmp;
    logic                 w_cmpFire;
    logic                 w_wordEq;
    logic                 w_idxOk;

    assign w_start   = (r_state == IDLE) && run;
    assign w_count   = (r_state == RUN) && run;
    assign w_timeout = w_nopHit || w_ccHit;
    assign w_idxOk   = (32'(cfg_idx) < GROUPS);

    mips_chk_timeout #(
        .WORD_WIDTH (WORD_WIDTH),
        .CC_WIDTH   (CC_WIDTH),
        .NOP_TIMEOUT(NOP_TIMEOUT),
        .CC_TIMEOUT (CC_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .nrst    (nrst),
        .i_start (w_start),
        .i_count (w_count),
        .i_inst  (inst),
        .o_cycles(cycles),
        .o_nopHit(w_nopHit),
        .o_ccHit (w_ccHit)
    );

    // Cumulative group end addresses; the last one is the total word count.
    always_comb begin
        logic [TOT_W-1:0] sum;
        sum = '0;
        for (int g = 0; g < GROUPS; g++) begin
            sum         = sum + TOT_W'(r_count[g]);
            w_cumEnd[g] = sum;
        end
    end

    assign w_total = w_cumEnd[GROUPS-1];

    // Owning group is the first whose end lies beyond the address, so empty groups never match.
    always_comb begin
        w_cmpGrp = '0;
        for (int g = GROUPS - 1; g >= 0; g--) begin
            if (r_cmpAddr < w_cumEnd[g]) begin
                w_cmpGrp = IDX_W'(g);
            end
        end
    end

    assign w_cmpFire = (r_state == CHECK) && r_cmpValid;
    assign w_lastCmp = w_cmpFire && (r_cmpAddr == w_total - TOT_W'(1));
    assign w_wordEq  = (act_rdata == exp_rdata);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (run) begin
                    if (!w_timeout) begin
                        w_stateNext = RUN;
                    end else begin
                        w_stateNext = (w_total == '0) ? DONE : CHECK;
                    end
                end
            end
            RUN: begin
                if (!run) begin
                    w_stateNext = IDLE;
                end else if (w_timeout) begin
                    w_stateNext = (w_total == '0) ? DONE : CHECK;
                end
            end
            CHECK: begin
                if (!run) begin
                    w_stateNext = IDLE;
                end else if (w_lastCmp) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (!run) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state == RUN) || (r_state == CHECK);
        done  = (r_state == DONE);
        rd_en = (r_state == CHECK) && (r_issueAddr < w_total);
    end

    assign rd_addr = r_issueAddr[ADDR_WIDTH-1:0];
    assign cause   = r_cause;

    // Read issue and one-cycle-delayed compare tag; memories return data a cycle after rd_en.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_issueAddr <= '0;
            r_cmpAddr   <= '0;
            r_cmpValid  <= 1'b0;
            r_cause     <= '0;
        end else begin
            if (r_state != CHECK) begin
                r_issueAddr <= '0;
                r_cmpValid  <= 1'b0;
            end else begin
                if (rd_en) begin
                    r_issueAddr <= r_issueAddr + TOT_W'(1);
                end
                r_cmpValid <= rd_en;
                r_cmpAddr  <= r_issueAddr;
            end
            if (w_start) begin
                r_cause <= '0;
            end
            if ((w_start || w_count) && w_timeout) begin
                r_cause[CAUSE_NOP] <= w_nopHit;
                r_cause[CAUSE_CC]  <= w_ccHit;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int g = 0; g < GROUPS; g++) begin
                r_count[g] <= '0;
                r_score[g] <= '0;
            end
        end else begin
            if ((r_state == IDLE) && cfg_wr && w_idxOk) begin
                r_count[cfg_idx] <= cfg_count;
            end
            if (w_start) begin
                for (int g = 0; g < GROUPS; g++) begin
                    r_score[g] <= '0;
                end
            end else if (w_cmpFire && w_wordEq && !(&r_score[w_cmpGrp])) begin
                r_score[w_cmpGrp] <= r_score[w_cmpGrp] + CNT_WIDTH'(1);
            end
        end
    end

    assign score = w_idxOk ? r_score[cfg_idx] : '0;

`ifdef MISMATCH_LOG_EN
    logic                  r_mmValid;
    logic [ADDR_WIDTH-1:0] r_mmAddr;
    logic [WORD_WIDTH-1:0] r_mmAct;
    logic [WORD_WIDTH-1:0] r_mmExp;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mmValid <= 1'b0;
            r_mmAddr  <= '0;
            r_mmAct   <= '0;
            r_mmExp   <= '0;
        end else begin
            r_mmValid <= w_cmpFire && !w_wordEq;
            if (w_cmpFire && !w_wordEq) begin
                r_mmAddr <= r_cmpAddr[ADDR_WIDTH-1:0];
                r_mmAct  <= act_rdata;
                r_mmExp  <= exp_rdata;
            end
        end
    end

    assign mm_valid = r_mmValid;
    assign mm_addr  = r_mmAddr;
    assign mm_act   = r_mmAct;
    assign mm_exp   = r_mmExp;
`else
    assign mm_valid = 1'b0;
    assign mm_addr  = '0;
    assign mm_act   = '0;
    assign mm_exp   = '0;
`endif

endmodule

// File: tb/tb_mips_result_checker.sv
// Scoreboard bench: each run's expected result is queued at launch and checked
// by an independent monitor when done rises (and on every mm_valid pulse).
module tb_mips_result_checker;

    localparam int WW   = 32;
    localparam int AW   = 12;
    localparam int NG   = 13;
    localparam int CW   = 8;
    localparam int CCW  = 16;
    localparam int NOPT = 20;
    localparam int CCT  = 50;
    localparam int IW   = $clog2(NG);

    typedef struct {
        logic [CCW-1:0]         cycles;
        logic [1:0]             cause;
        int                     total;
        logic [NG-1:0][CW-1:0]  scores;
    } runExp_t;

    typedef struct {
        logic [AW-1:0] mAddr;
        logic [WW-1:0] mAct;
        logic [WW-1:0] mExp;
    } mmExp_t;

    logic          clk = 1'b0;
    logic          nrst;
    logic          run;
    logic [WW-1:0] inst;
    logic          cfgWr;
    logic [IW-1:0] stimIdx;
    logic [IW-1:0] monIdx;
    logic          monOwns;
    logic [IW-1:0] cfgIdx;
    logic [CW-1:0] cfgCount;
    logic          rdEn;
    logic [AW-1:0] rdAddr;
    logic [WW-1:0] actRdata = '0;
    logic [WW-1:0] expRdata = '0;
    logic [CW-1:0] score;
    logic [CCW-1:0] cycles;
    logic [1:0]    cause;
    logic          busy;
    logic          done;
    logic          mmValid;
    logic [AW-1:0] mmAddr;
    logic [WW-1:0] mmAct;
    logic [WW-1:0] mmExp;

    logic [WW-1:0] actMem [1 << AW];
    logic [WW-1:0] expMem [1 << AW];

    runExp_t expQ [$];
    mmExp_t  mmQ [$];
    int      nChecks = 0;
    int      nPass = 0;
    int      checkedRuns = 0;

    assign cfgIdx = monOwns ? monIdx : stimIdx;

    mips_result_checker #(
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW),
        .GROUPS     (NG),
        .CNT_WIDTH  (CW),
        .CC_WIDTH   (CCW),
        .NOP_TIMEOUT(NOPT),
        .CC_TIMEOUT (CCT)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .run      (run),
        .inst     (inst),
        .cfg_wr   (cfgWr),
        .cfg_idx  (cfgIdx),
        .cfg_count(cfgCount),
        .rd_en    (rdEn),
        .rd_addr  (rdAddr),
        .act_rdata(actRdata),
        .exp_rdata(expRdata),
        .score    (score),
        .cycles   (cycles),
        .cause    (cause),
        .busy     (busy),
        .done     (done),
        .mm_valid (mmValid),
        .mm_addr  (mmAddr),
        .mm_act   (mmAct),
        .mm_exp   (mmExp)
    );

    always #20 clk = ~clk;

    // Synchronous-read models of datamem and outmem.
    always @(posedge clk) begin
        if (rdEn) begin
            actRdata <= actMem[rdAddr];
            expRdata <= expMem[rdAddr];
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint req);
        nChecks++;
        if (act == req) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic setCounts(input int c0, input int c1, input int c2, input int c3);
        int cnt [4];
        cnt = '{c0, c1, c2, c3};
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            cfgWr    = 1'b1;
            stimIdx  = IW'(g);
            cfgCount = CW'(cnt[g]);
        end
        @(negedge clk);
        cfgWr   = 1'b0;
        stimIdx = '0;
    endtask

    task automatic fillMem(input logic [WW-1:0] base);
        for (int i = 0; i < 16; i++) begin
            actMem[i] = base + WW'(i);
            expMem[i] = base + WW'(i);
        end
    endtask

    task automatic applyStimulus(input runExp_t e, input logic [WW-1:0] instVal, input bit checkClear);
        int  target;
        bit  seen;
        target = checkedRuns + 1;
        expQ.push_back(e);
        inst = instVal;
        @(negedge clk);
        run = 1'b1;
        if (checkClear) begin
            @(negedge clk);
            stimIdx = '0;
            #1;
            checkOutput("restart_score0", score, 0);
            stimIdx = IW'(1);
            #1;
            checkOutput("restart_score1", score, 0);
            stimIdx = '0;
        end
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (checkedRuns >= target) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checkOutput("run_done_timeout", 0, 1);
            expQ.delete();
        end
        run = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: tracks the CHECK read burst and scores each completed run.
    initial begin : monitor
        bit      prevBusy;
        bit      prevDone;
        bit      curBusy;
        bit      curDone;
        int      cyc;
        int      firstRd;
        int      rdCnt;
        runExp_t e;
        mmExp_t  m;
        prevBusy = 1'b0;
        prevDone = 1'b0;
        cyc      = 0;
        firstRd  = -1;
        rdCnt    = 0;
        monOwns  = 1'b0;
        monIdx   = '0;
        forever begin
            @(negedge clk);
            cyc++;
            curBusy = busy;
            curDone = done;
            if (curBusy && !prevBusy) begin
                firstRd = -1;
                rdCnt   = 0;
            end
            if (rdEn) begin
                rdCnt++;
                if (firstRd < 0) firstRd = cyc;
            end
            if (mmValid) begin
                if (mmQ.size() == 0) begin
                    checkOutput("mm_unexpected", 1, 0);
                end else begin
                    m = mmQ.pop_front();
                    checkOutput("mm_addr", mmAddr, m.mAddr);
                    checkOutput("mm_act", mmAct, m.mAct);
                    checkOutput("mm_exp", mmExp, m.mExp);
                end
            end
            if (curDone && !prevDone) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("cycles", cycles, e.cycles);
                    checkOutput("cause", cause, e.cause);
                    checkOutput("read_count", rdCnt, e.total);
                    if (e.total > 0) begin
                        checkOutput("check_len", cyc - firstRd, e.total + 1);
                    end
                    monOwns = 1'b1;
                    for (int g = 0; g < NG; g++) begin
                        monIdx = IW'(g);
                        #1;
                        checkOutput($sformatf("score[%0d]", g), score, e.scores[g]);
                    end
                    monOwns = 1'b0;
                end
                checkedRuns++;
            end
            prevBusy = curBusy;
            prevDone = curDone;
        end
    end

    initial begin : watchdog
        #4000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        runExp_t e;
        nrst     = 1'b0;
        run      = 1'b0;
        inst     = '0;
        cfgWr    = 1'b0;
        stimIdx  = '0;
        cfgCount = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            actMem[i] = '0;
            expMem[i] = '0;
        end
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rd_en", rdEn, 0);
        checkOutput("rst_cycles", cycles, 0);
        checkOutput("rst_cause", cause, 0);
        checkOutput("rst_score", score, 0);
        checkOutput("rst_mm_valid", mmValid, 0);
        nrst = 1'b1;
        @(negedge clk);

        $display("[TB] NOP timeout, counts {3,2}, all equal");
        setCounts(3, 2, 0, 0);
        fillMem(32'h0000_0100);
        e.cycles = 16'd20; e.cause = 2'b01; e.total = 5; e.scores = '0;
        e.scores[0] = 8'd3; e.scores[1] = 8'd2;
        applyStimulus(e, '0, 1'b0);

        $display("[TB] counts {4}, word 2 differs");
        setCounts(4, 0, 0, 0);
        fillMem(32'h0000_0200);
        actMem[2] = 32'h1;
        expMem[2] = 32'h2;
`ifdef MISMATCH_LOG_EN
        mmQ.push_back('{mAddr: 12'd2, mAct: 32'h1, mExp: 32'h2});
`endif
        e.cycles = 16'd20; e.cause = 2'b01; e.total = 4; e.scores = '0;
        e.scores[0] = 8'd3;
        applyStimulus(e, '0, 1'b0);
        fillMem(32'h0000_0300);

        $display("[TB] cycle timeout, no NOPs");
        setCounts(1, 0, 0, 0);
        e.cycles = 16'd50; e.cause = 2'b10; e.total = 1; e.scores = '0;
        e.scores[0] = 8'd1;
        applyStimulus(e, 32'h2402_0001, 1'b0);

        $display("[TB] counts {0,2,0,1} with empty groups");
        setCounts(0, 2, 0, 1);
        e.cycles = 16'd20; e.cause = 2'b01; e.total = 3; e.scores = '0;
        e.scores[1] = 8'd2; e.scores[3] = 8'd1;
        applyStimulus(e, '0, 1'b0);

        $display("[TB] abort in 5th CHECK cycle, then restart");
        setCounts(3, 2, 0, 0);
        inst = '0;
        @(negedge clk);
        run = 1'b1;
        begin
            bit gotRd;
            gotRd = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (rdEn) begin
                    gotRd = 1'b1;
                    break;
                end
            end
            checkOutput("abort_reach_check", gotRd, 1);
        end
        repeat (4) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_busy", busy, 0);
        e.cycles = 16'd20; e.cause = 2'b01; e.total = 5; e.scores = '0;
        e.scores[0] = 8'd3; e.scores[1] = 8'd2;
        applyStimulus(e, '0, 1'b1);

        $display("[TB] reset asserted mid-RUN");
        inst = '0;
        @(negedge clk);
        run = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("midrun_busy", busy, 1);
        nrst = 1'b0;
        run  = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_rd_en", rdEn, 0);
        checkOutput("midrst_cycles", cycles, 0);
        checkOutput("midrst_cause", cause, 0);
        checkOutput("midrst_score", score, 0);
        checkOutput("midrst_mm_valid", mmValid, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        e.cycles = 16'd20; e.cause = 2'b01; e.total = 0; e.scores = '0;
        applyStimulus(e, '0, 1'b0);

        checkOutput("mm_pending", mmQ.size(), 0);
        checkOutput("exp_pending", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/mips_result_checker.md
# mips_result_checker

Synthesizable run monitor and scoreboard for the pipelined MIPS lab harness. It watches the core's instruction bus and ends a run on a NOP-streak timeout or a cycle-count timeout. It then compares the actual data memory against the expected-result memory one word per cycle, and keeps a pass count for each instruction group. It sits beside `pipelined_mips`, `datamem` and `outmem`, and generalises the group count, case counts, widths and timeouts.

## Interface
- WORD_WIDTH, 32, instruction/data word width
- ADDR_WIDTH, 12, word-address width of the compared region
- GROUPS, 13, number of instruction groups (1..32)
- CNT_WIDTH, 8, width of per-group case count and score
- CC_WIDTH, 16, cycle counter width
- NOP_TIMEOUT, 20, consecutive all-zero instructions that end a run
- CC_TIMEOUT, 10000, cycle count that ends a run
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- run  in  1  high while the core is out of reset; a rising level starts a run
- inst  in  WORD_WIDTH  fetched instruction being monitored
- cfg_wr  in  1  write case count (accepted only in IDLE)
- cfg_idx  in  $clog2(GROUPS)  group index for cfg_wr / score read
- cfg_count  in  CNT_WIDTH  case count for group cfg_idx
- rd_en  out  1  read strobe to both memories
- rd_addr  out  ADDR_WIDTH  word address, shared by both memories
- act_rdata  in  WORD_WIDTH  actual word, valid 1 cycle after rd_en
- exp_rdata  in  WORD_WIDTH  expected word, valid 1 cycle after rd_en
- score  out  CNT_WIDTH  score of group cfg_idx (combinational read)
- cycles  out  CC_WIDTH  cycles counted in the last run
- cause  out  2  [0] NOP timeout, [1] cycle timeout
- busy  out  1  in RUN or CHECK
- done  out  1  in DONE
- mm_valid / mm_addr / mm_act / mm_exp  out  1 / ADDR_WIDTH / WORD_WIDTH / WORD_WIDTH  mismatch report

## Operation
- States: IDLE, RUN, CHECK, DONE.
- IDLE:
  - cfg_wr loads the case-count register.
  - run=1 moves to RUN. On entry, the cycle counter, NOP counter, cause and all scores are cleared.
- RUN, every cycle:
  - cycles increments, saturating at all-ones.
  - If inst==0 the NOP counter increments; otherwise it clears.
  - NOP counter == NOP_TIMEOUT sets cause[0]. cycles >= CC_TIMEOUT sets cause[1].
  - If either condition holds, go to CHECK. If both hold in the same cycle, both cause bits are set.
- CHECK:
  - rd_addr steps from 0 to total−1, one per cycle, with rd_en high. total is the sum of all case counts, at ADDR_WIDTH+1 bits.
  - The compare uses the data returned one cycle later.
  - On equal words, the score of the current group increments.
  - The current group advances when the compare address reaches that group's cumulative end. Groups with a count of 0 are skipped.
  - After the last compare, go to DONE. If total==0, go directly to DONE.
- DONE: holds scores, cycles and cause. run=0 returns to IDLE with results retained.
- Abort: run=0 in RUN or CHECK goes to IDLE. done is never asserted for that run, and the partial results are undefined until the next start.
- cfg_wr outside IDLE is ignored.

## Timing
- Reset values: state IDLE, all counters and scores 0, every output 0, all case counts 0.
- First cycle counted is the first clk edge with run=1 observed in IDLE.
- Read pipeline: address issued at edge t, data sampled at t+1, score register updated at t+1.
- Throughput is 1 word per cycle. CHECK lasts total+1 cycles.
- mm_valid pulses for 1 cycle, in the same cycle the score would have incremented.
- Scores saturate at all-ones.

## Configuration
- MISMATCH_LOG_EN defined: mm_* ports are driven. mm_addr is the compared word address; mm_act and mm_exp are the compared words.
- MISMATCH_LOG_EN undefined: mm_* ports remain present but are tied to 0, and no capture registers are built.

## Structure
- Package `mips_chk_pkg` holds:
  - the state enum (IDLE/RUN/CHECK/DONE);
  - the cause bit positions;
  - the default timeout constants.
- Sub-module `mips_chk_timeout`: the RUN-phase cycle counter and NOP counter. Outputs are `cycles` and the two timeout flags.
- The top level holds the FSM, the case-count and score register files, and the compare pipeline.

## Test plan
- Counts {3,2}, memories equal, inst=0 from the start → CHECK after 20 cycles, cause=01, scores {3,2}, done=1.
- Counts {4}, word 2 differs (act 0x1, exp 0x2), with MISMATCH_LOG_EN defined → score 3, single mm_valid with mm_addr=2, mm_act=0x1, mm_exp=0x2.
- CC_TIMEOUT=50, inst never 0 → cycles=50, cause=10.
- Counts {0,2,0,1}, all equal → scores {0,2,0,1}. CHECK lasts 4 cycles.
- run dropped in the 5th CHECK cycle → IDLE, done=0. Re-raising run clears scores and the next run completes normally.
- nrst asserted mid-RUN → all outputs 0 immediately and all case counts 0.
